// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Optional message locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]     req_last,
`endif
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    localparam logic [1:0] S_ARB       = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [ID_W-1:0]  winner;
    logic             do_grant;
    logic [7:0]       win_data;

`ifdef UART_ARB_LOCK_EN
    logic locked;

    // While a message is open only its owner (the last grantee) may compete.
    always_comb begin
        eligible = req_valid;
        if (locked) begin
            eligible             = '0;
            eligible[last_grant] = req_valid[last_grant];
        end
    end
`else
    assign eligible = req_valid;
`endif

    // Search starts one past the previous winner and wraps modulo N_REQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign do_grant = (state == S_ARB) && tx_data_ready && found;
    assign win_data = req_data[8*int'(winner) +: 8];

    always_comb begin
        req_ready = '0;
        if (do_grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_ARB;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            busy          <= 1'b0;
            last_grant    <= ID_W'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            locked        <= 1'b0;
`endif
        end else begin
            case (state)
                S_ARB: begin
                    if (do_grant) begin
                        tx_data       <= win_data;
                        tx_data_valid <= 1'b1;
                        grant_id      <= winner;
                        busy          <= 1'b1;
                        last_grant    <= winner;
`ifdef UART_ARB_LOCK_EN
                        locked        <= !req_last[winner];
`endif
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_data_valid <= 1'b0;
                    state         <= S_WAIT_BUSY;
                end
                // The transmitter must first acknowledge the byte by dropping ready.
                S_WAIT_BUSY: begin
                    if (!tx_data_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_data_ready) begin
                        busy  <= 1'b0;
                        state <= S_ARB;
                    end
                end
                default: begin
                    state <= S_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx ready model.
// Expected byte order is pushed at stimulus time and compared as bytes issue.
module tb_uart_tx_arbiter;

    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [1:0]  req_last;
`endif
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [0:0]  grant_id;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last      (req_last),
`endif
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         gid_q[$];
    int         pulse_t[$];

    logic hold_off = 1'b0;
    int   frame_cnt;
    int   cyc = 0;
    int   vld_pulses = 0;
    int   rdy_pulses = 0;
    int   busy_cycles = 0;
    int   viol = 0;
    logic prev_vld = 1'b0;

    // Behavioural transmitter: drops ready after a valid, holds it low for a frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_ready <= 1'b0;
            frame_cnt     <= 0;
        end else if (tx_data_valid) begin
            frame_cnt     <= FRAME;
            tx_data_ready <= 1'b0;
        end else if (frame_cnt > 1) begin
            frame_cnt <= frame_cnt - 1;
        end else begin
            frame_cnt     <= 0;
            tx_data_ready <= !hold_off;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (tx_data_valid) begin
                got_q.push_back(tx_data);
                gid_q.push_back(int'(grant_id));
                pulse_t.push_back(cyc);
                vld_pulses = vld_pulses + 1;
                if (prev_vld) viol = viol + 1;
                if (frame_cnt != 0) viol = viol + 1;
            end
            if (req_ready != 2'b00) rdy_pulses = rdy_pulses + 1;
            if ((req_ready & (req_ready - 2'd1)) != 2'b00) viol = viol + 1;
            if (!tx_data_ready && req_ready != 2'b00) viol = viol + 1;
            if (busy) busy_cycles = busy_cycles + 1;
        end
        prev_vld = tx_data_valid;
    end

    // Requesters hold valid/data until accepted, then present their next byte.
    initial begin
        logic [1:0] acc;
        req_valid = 2'b00;
        req_data  = 16'h0000;
`ifdef UART_ARB_LOCK_EN
        req_last  = 2'b00;
`endif
        forever begin
            @(negedge clk);
            req_valid[0]   = (src0.size() != 0);
            req_data[7:0]  = (src0.size() != 0) ? src0[0][7:0] : 8'h00;
            req_valid[1]   = (src1.size() != 0);
            req_data[15:8] = (src1.size() != 0) ? src1[0][7:0] : 8'h00;
`ifdef UART_ARB_LOCK_EN
            req_last[0]    = (src0.size() != 0) ? src0[0][8] : 1'b0;
            req_last[1]    = (src1.size() != 0) ? src1[0][8] : 1'b0;
`endif
            #4;
            acc = req_valid & req_ready & {2{rst_n}};
            @(posedge clk);
            if (rst_n && acc[0] && src0.size() != 0) void'(src0.pop_front());
            if (rst_n && acc[1] && src1.size() != 0) void'(src1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic hold);
        hold_off = hold;
        rst_n = 1'b0;
        src0.delete();
        src1.delete();
        exp_q.delete();
        got_q.delete();
        gid_q.delete();
        pulse_t.delete();
        vld_pulses = 0;
        rdy_pulses = 0;
        busy_cycles = 0;
        viol = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget, output bit timed_out);
        int i = 0;
        while (got_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        timed_out = (got_q.size() < n);
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int i = 0;
        while ((busy || !tx_data_ready || src0.size() != 0 || src1.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        timed_out = (busy || !tx_data_ready);
    endtask

    task automatic test_reset;
        hold_off = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_cmp++;
        if (tx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", tx_data_valid); end
        n_cmp++;
        if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %h expected 0", grant_id); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    endtask

    task automatic test_single;
        bit to;
        do_reset(1'b0);
        src0.push_back({1'b1, 8'h41});
        exp_q.push_back(8'h41);
        wait_got(1, 60, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL single_timeout: got %0d bytes expected 1", got_q.size()); end
        wait_idle(200, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL single_idle_timeout: busy %b ready %b", busy, tx_data_ready); end
        if (got_q.size() != 0) begin
            n_cmp++;
            if (got_q.pop_front() !== exp_q.pop_front()) begin n_fail++; $display("FAIL single_byte: wrong byte, expected 41"); end
            n_cmp++;
            if (gid_q.pop_front() !== 0) begin n_fail++; $display("FAIL single_grant_id: expected 0"); end
        end
        n_cmp++;
        if (rdy_pulses !== 1) begin n_fail++; $display("FAIL single_ready_pulses: got %0d expected 1", rdy_pulses); end
        n_cmp++;
        if (vld_pulses !== 1) begin n_fail++; $display("FAIL single_valid_pulses: got %0d expected 1", vld_pulses); end
        n_cmp++;
        if (busy_cycles !== FRAME + 2) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", busy_cycles, FRAME + 2); end
        n_cmp++;
        if (viol !== 0) begin n_fail++; $display("FAIL single_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_round_robin;
        bit to;
        logic [7:0] g;
        logic [7:0] e;
        do_reset(1'b0);
        src0.push_back({1'b1, 8'h11}); src0.push_back({1'b1, 8'h11});
        src1.push_back({1'b1, 8'h22}); src1.push_back({1'b1, 8'h22});
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        wait_got(4, 400, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL rr_timeout: got %0d bytes expected 4", got_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL rr_order: got %h expected %h", g, e); end
        end
        if (pulse_t.size() >= 2) begin
            n_cmp++;
            if (pulse_t[1] - pulse_t[0] !== FRAME + 3) begin
                n_fail++; $display("FAIL rr_spacing: got %0d expected %0d", pulse_t[1] - pulse_t[0], FRAME + 3);
            end
        end
        n_cmp++;
        if (viol !== 0) begin n_fail++; $display("FAIL rr_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_hold_off;
        bit to;
        int bad = 0;
        do_reset(1'b1);
        src1.push_back({1'b1, 8'h33});
        exp_q.push_back(8'h33);
        repeat (8) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 2'b00 || tx_data_valid !== 1'b0) begin
                n_fail++; bad++;
                $display("FAIL holdoff_quiet: ready %b valid %b expected 00 0", req_ready, tx_data_valid);
            end
        end
        hold_off = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL holdoff_ready: got %b expected 10", req_ready); end
        @(negedge clk);
        n_cmp++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'h33 || grant_id !== 1'b1) begin
            n_fail++; $display("FAIL holdoff_issue: valid %b data %h id %h expected 1 33 1", tx_data_valid, tx_data, grant_id);
        end
        wait_got(1, 20, to);
        wait_idle(200, to);
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL holdoff_byte: got %0d bytes expected one byte 33", got_q.size());
        end
    endtask

    task automatic test_lock;
        bit to;
        logic [7:0] g;
        logic [7:0] e;
        do_reset(1'b0);
        src0.push_back({1'b0, 8'h61}); src0.push_back({1'b0, 8'h62}); src0.push_back({1'b1, 8'h63});
        src1.push_back({1'b1, 8'h7A});
`ifdef UART_ARB_LOCK_EN
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h7A);
`else
        exp_q.push_back(8'h61); exp_q.push_back(8'h7A); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
`endif
        wait_got(4, 400, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL lock_timeout: got %0d bytes expected 4", got_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL lock_order: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (viol !== 0) begin n_fail++; $display("FAIL lock_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_back_to_back;
        bit to;
        logic [7:0] g;
        logic [7:0] e;
        int id;
        do_reset(1'b0);
        src1.push_back({1'b1, 8'h01}); src1.push_back({1'b1, 8'h02}); src1.push_back({1'b1, 8'h03});
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        wait_got(3, 300, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout: got %0d bytes expected 3", got_q.size()); end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            id = gid_q.pop_front();
            n_cmp++;
            if (g !== e || id !== 1) begin n_fail++; $display("FAIL b2b_byte: got %h id %0d expected %h id 1", g, id, e); end
        end
        if (pulse_t.size() >= 3) begin
            n_cmp++;
            if (pulse_t[2] - pulse_t[1] !== FRAME + 3) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", pulse_t[2] - pulse_t[1], FRAME + 3);
            end
        end
    endtask

    task automatic test_reset_abort;
        bit to;
        int i = 0;
        logic [7:0] g;
        logic [7:0] e;
        do_reset(1'b0);
        src0.push_back({1'b1, 8'h55});
        src1.push_back({1'b1, 8'hAA});
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        while (!(busy && frame_cnt == FRAME / 2) && i < 100) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (i >= 100) begin n_fail++; $display("FAIL abort_reach_frame: frame_cnt %0d expected %0d", frame_cnt, FRAME / 2); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || tx_data !== 8'h00 || tx_data_valid !== 1'b0 || grant_id !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL abort_async_reset: busy %b data %h valid %b id %h ready %b expected 0 00 0 0 00",
                               busy, tx_data, tx_data_valid, grant_id, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_got(2, 100, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL abort_timeout: got %0d bytes expected 2", got_q.size()); end
        wait_idle(200, to);
        repeat (FRAME + 10) @(negedge clk);
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL abort_order: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (grant_id !== 1'b1) begin n_fail++; $display("FAIL abort_grant_id: got %h expected 1", grant_id); end
        n_cmp++;
        if (vld_pulses !== 2) begin n_fail++; $display("FAIL abort_no_retransmit: got %0d pulses expected 2", vld_pulses); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_off();
        test_lock();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
